// File: rtl/uart_rx_if.sv
// Receiver-side bundle for the 8N1 UART: serial line in, byte/status out.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  // master: the receiver itself; slave: whoever drives the line and consumes bytes
  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit start validation, centre
// sampling, one-cycle DV / framing-error strobes and line-break recovery.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input logic       i_Clock,
  input logic       i_Reset,
  uart_rx_if.master bus
);

  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } state_t;

  logic          rx_meta, rx_sync;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          active_q, active_d;
  logic          ferr_q, ferr_d;

  // State and output registers; the two-flop synchroniser resets to idle-high
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= 8'h00;
      byte_q   <= 8'h00;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_meta  <= bus.i_Rx_Serial;
      rx_sync  <= rx_meta;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    unique case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_d  = START;
          cnt_d    = '0;
          active_d = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CW'(HALF)) begin
          cnt_d = '0;
          idx_d = 3'd0;
          if (!rx_sync) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          shadow_d[idx_q] = rx_sync;
          cnt_d           = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_sync) begin
            byte_d  = shadow_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      CLEANUP: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end

      // Hold off new frames until the line returns high
      BREAK: begin
        if (rx_sync) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  assign bus.o_Rx_DV        = dv_q;
  assign bus.o_Rx_Byte      = byte_q;
  assign bus.o_Rx_Active    = active_q;
  assign bus.o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-accurate 8N1 frames driven on the line,
// outputs compared against hand-computed values.
module tb_uart_rx;

  localparam int unsigned CPB = 87;
  localparam int unsigned DV_OFFSET = 3 + 43 + 9 * 87;  // 829 edges after E0

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  int cyc      = 0;
  int e0       = 0;
  int dv_cnt   = 0;
  int dv_cyc   = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int act_rise = 0;
  logic act_prev = 1'b0;
  logic [7:0] dv_bytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (bus.o_Rx_DV === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_bytes.push_back(bus.o_Rx_Byte);
    end
    if (bus.o_Rx_Frame_Err === 1'b1) ferr_cnt++;
    if (bus.o_Rx_DV === 1'b1 && bus.o_Rx_Frame_Err === 1'b1) both_cnt++;
    if (bus.o_Rx_Active === 1'b1 && act_prev !== 1'b1) act_rise++;
    act_prev = bus.o_Rx_Active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.i_Rx_Serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame starting at a falling clock edge; E0 is the next rising edge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.i_Rx_Serial = 1'b0;
    e0 = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      bus.i_Rx_Serial = b[k];
      repeat (CPB) @(negedge clk);
    end
    bus.i_Rx_Serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  int dv_base, ferr_base, rise_base;

  initial begin
    rst = 1'b1;
    bus.i_Rx_Serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("reset_dv",     32'(bus.o_Rx_DV),        32'd0);
    check("reset_byte",   32'(bus.o_Rx_Byte),      32'h00);
    check("reset_active", 32'(bus.o_Rx_Active),    32'd0);
    check("reset_ferr",   32'(bus.o_Rx_Frame_Err), 32'd0);

    // Idle line produces nothing
    idle(2000);
    check("idle_dv_cnt",   32'(dv_cnt),   32'd0);
    check("idle_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("idle_active",   32'(bus.o_Rx_Active), 32'd0);

    // Single byte 0x4B with exact DV timing
    send_frame(8'h4B, 1'b1);
    idle(10);
    check("single_dv_cnt",  32'(dv_cnt),   32'd1);
    check("single_dv_time", 32'(dv_cyc - e0), 32'(DV_OFFSET));
    check("single_byte",    32'(bus.o_Rx_Byte), 32'h4B);
    check("single_ferr",    32'(ferr_cnt), 32'd0);
    check("single_active",  32'(bus.o_Rx_Active), 32'd0);

    // Back-to-back frames 75 then 58
    dv_bytes.delete();
    send_frame(8'd75, 1'b1);
    send_frame(8'd58, 1'b1);
    check("b2b_second_time", 32'(dv_cyc - e0), 32'(DV_OFFSET));
    idle(200);
    check("b2b_count", 32'(dv_bytes.size()), 32'd2);
    check("b2b_byte0", 32'(dv_bytes[0]), 32'h4B);
    check("b2b_byte1", 32'(dv_bytes[1]), 32'h3A);
    check("b2b_ferr",  32'(ferr_cnt), 32'd0);

    // 20-cycle glitch is rejected, then 0xA5 received
    dv_base   = dv_cnt;
    ferr_base = ferr_cnt;
    rise_base = act_rise;
    bus.i_Rx_Serial = 1'b0;
    repeat (20) @(negedge clk);
    idle(100);
    check("glitch_active_rise", 32'(act_rise - rise_base), 32'd1);
    check("glitch_active_low",  32'(bus.o_Rx_Active), 32'd0);
    check("glitch_dv",          32'(dv_cnt - dv_base), 32'd0);
    check("glitch_ferr",        32'(ferr_cnt - ferr_base), 32'd0);
    check("glitch_byte_held",   32'(bus.o_Rx_Byte), 32'h3A);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("after_glitch_dv",   32'(dv_cnt - dv_base), 32'd1);
    check("after_glitch_byte", 32'(bus.o_Rx_Byte), 32'hA5);

    // Framing error on 0x3C, then a 30-bit break
    dv_base   = dv_cnt;
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (30 * CPB) @(negedge clk);
    check("ferr_pulse",        32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_no_dv",        32'(dv_cnt - dv_base), 32'd0);
    check("ferr_byte_kept",    32'(bus.o_Rx_Byte), 32'hA5);
    check("break_active_high", 32'(bus.o_Rx_Active), 32'd1);
    idle(3 * CPB);
    check("break_release_active", 32'(bus.o_Rx_Active), 32'd0);
    check("break_no_more_ferr",   32'(ferr_cnt - ferr_base), 32'd1);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("after_break_dv",   32'(dv_cnt - dv_base), 32'd1);
    check("after_break_byte", 32'(bus.o_Rx_Byte), 32'h5A);

    // Reset during data bit 4 of 0xFF
    dv_base   = dv_cnt;
    ferr_base = ferr_cnt;
    bus.i_Rx_Serial = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.i_Rx_Serial = 1'b1;
    repeat (4 * CPB + 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_byte",   32'(bus.o_Rx_Byte),      32'h00);
    check("midrst_active", 32'(bus.o_Rx_Active),    32'd0);
    check("midrst_dv",     32'(bus.o_Rx_DV),        32'd0);
    check("midrst_ferr",   32'(bus.o_Rx_Frame_Err), 32'd0);
    idle(CPB - 41 + 4 * CPB + 200);
    check("midrst_no_dv",   32'(dv_cnt - dv_base),     32'd0);
    check("midrst_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("after_rst_dv",   32'(dv_cnt - dv_base), 32'd1);
    check("after_rst_byte", 32'(bus.o_Rx_Byte), 32'h81);

    check("pulse_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), line idles high. It is the receiving end of the link driven by `uart_tx`, sharing its `CLKS_PER_BIT` bit-timing convention. The block:
- synchronises the asynchronous serial input;
- validates the start bit at mid-bit and samples each bit at its centre;
- presents each received byte with a one-cycle data-valid strobe;
- flags framing errors and recovers from line breaks.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200 baud). Legal range ≥ 4.
- `HALF` (derived, not overridable) = (`CLKS_PER_BIT`-1)/2, integer division.

Ports:
- `i_Clock`, input, 1 bit: system clock. This is the only clock.
- `i_Reset`, input, 1 bit: reset, **synchronous and active-high**.
- `i_Rx_Serial`, input, 1 bit: asynchronous serial line, idle high.
- `o_Rx_DV`, output, 1 bit: one-cycle pulse when `o_Rx_Byte` is updated with a good frame.
- `o_Rx_Byte`, output, 8 bits: last correctly framed byte. Held until the next good frame.
- `o_Rx_Active`, output, 1 bit: high from start-bit detection until the return to IDLE.
- `o_Rx_Frame_Err`, output, 1 bit: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** two flip-flops on `i_Rx_Serial`, both reset to 1. All decisions use the second stage, `r_Rx`.
- **Counter:** the bit-cycle counter is $clog2(`CLKS_PER_BIT`) bits wide. The bit index is 3 bits.
- **States:** IDLE, START, DATA, STOP, CLEANUP, BREAK.
- **IDLE:**
  - `r_Rx`==0 → START, counter cleared.
  - Otherwise remain in IDLE.
- **START:** counter increments each cycle until it reaches `HALF`. At that cycle:
  - `r_Rx`==0 → DATA, with counter and bit index cleared.
  - `r_Rx`==1 → IDLE. This is a glitch: no outputs pulse.
- **DATA:** counter counts 0..`CLKS_PER_BIT`-1. At `CLKS_PER_BIT`-1:
  - shift `r_Rx` into shadow bit [index];
  - clear the counter.
  - After index 7 → STOP. Otherwise increment the index.
- **STOP:** counter counts to `CLKS_PER_BIT`-1, then samples:
  - `r_Rx`==1 → copy the shadow register to `o_Rx_Byte`, pulse `o_Rx_DV`, go to CLEANUP.
  - `r_Rx`==0 → pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, go to BREAK.
- **CLEANUP:** one cycle; deasserts `o_Rx_Active`, then → IDLE.
- **BREAK:** remain until `r_Rx`==1, then → IDLE. No new frame is accepted while the line stays low.
- **`o_Rx_Active`:** set on IDLE→START. Cleared in CLEANUP, on BREAK→IDLE, and on START→IDLE (glitch).
- **Reset values:** state IDLE, counter 0, index 0, shadow 0x00, `o_Rx_Byte` 0x00, `o_Rx_DV` 0, `o_Rx_Active` 0, `o_Rx_Frame_Err` 0.
- **Reset priority:** reset overrides all other logic. Asserting reset mid-frame aborts the frame with no DV or error pulse.
- **Pulse exclusivity:** `o_Rx_DV` and `o_Rx_Frame_Err` are never high together.

## Timing
- Let E0 be the first `i_Clock` edge at which `i_Rx_Serial` is sampled low. The chain then runs:
  - `r_Rx`==0 at E0+2 → START entered at E0+3.
  - Start check at edge E0+3+`HALF`.
  - Data bit k (k=0..7) sampled at E0+3+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at E0+3+`HALF`+9·`CLKS_PER_BIT`.
- `o_Rx_DV` or `o_Rx_Frame_Err` is high for exactly the one cycle after the stop-sample edge.
- `o_Rx_Byte` becomes valid in the same cycle as `o_Rx_DV`.
- Back-to-back frames: a start edge arriving one bit time after the stop-bit start is received correctly. This holds because CLEANUP+IDLE consume 2 cycles, well under `HALF`.
- Glitch rejection: a low pulse shorter than about `HALF`+1 cycles is rejected.

## Test plan
All scenarios use `CLKS_PER_BIT`=87 and a 100 ns clock (bit time 8700 ns).
- **Reset values:** after reset, all outputs are 0 and `o_Rx_Byte`=0x00. Idle-high line for 2000 cycles → no pulses.
- **Single byte:** drive 0x4B (decimal 75) bit-accurately → exactly one `o_Rx_DV` pulse at E0+3+43+9·87, `o_Rx_Byte`=0x4B, no `o_Rx_Frame_Err`.
- **Loopback:** `uart_tx` sends 75, then 58 back-to-back → DV pulses carry 0x4B then 0x3A. `o_Rx_Active` is low between frames for ≤ 2 cycles plus idle.
- **Glitch:** low pulse of 20 cycles → returns to IDLE, `o_Rx_Active` pulses briefly, no DV or error. A following valid 0xA5 is received correctly.
- **Framing error and break:**
  - Frame 0x3C with stop bit 0 → one `o_Rx_Frame_Err` pulse, `o_Rx_Byte` keeps its previous value.
  - Line held low for 30 bit times → no further pulses.
  - Line released, then 0x5A sent → DV with 0x5A.
- **Reset mid-frame:** assert `i_Reset` for 1 cycle during data bit 4 of 0xFF → all outputs return to reset values with no pulses. The next frame, 0x81, is received correctly.
